i2c_slave: RTL and testbench

Single-address I2C target that answers the team's I2C master over the same open-drain pad interface. It oversamples SCL/SDA on the system clock and detects START/STOP. It acknowledges its own 7-bit address, delivers written bytes to the host as one-cycle strobes and shifts out host-supplied bytes on reads. It sits behind the pad tri-state buffers and has no clock stretching.

---
 rtl/i2c_slave.sv | 195 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// Single-address I2C target on oversampled open-drain pads, no clock stretching.
// Latency: pad edge -> event 3 clk, SDA drive change 4 clk after the SCL pad fall.
// Backpressure: none; host must present tx_data_i before tx_req_o and take rx_data_o on rx_valid_o.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       scl_oe,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       rw_o,
    output logic       stop_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ACK_ADDR = 3'd2;
    localparam logic [2:0] S_RX_BYTE  = 3'd3;
    localparam logic [2:0] S_ACK_RX   = 3'd4;
    localparam logic [2:0] S_TX_BYTE  = 3'd5;
    localparam logic [2:0] S_RX_ACK   = 3'd6;

    logic       scl_s1, scl_s, scl_d;
    logic       sda_s1, sda_s, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    // Second-edge marker: ACK driven / last TX bit clocked / master ACK seen.
    logic       phase;

    assign scl_o  = 1'b1;
    assign scl_oe = 1'b0;
    assign sda_oe = !sda_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s  <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s  <= scl_s1;
            scl_d  <= scl_s;
            sda_s1 <= sda_i;
            sda_s  <= sda_s1;
            sda_d  <= sda_s;
        end
    end

    assign scl_rise  = scl_s && !scl_d;
    assign scl_fall  = !scl_s && scl_d;
    assign start_det = scl_s && scl_d && sda_d && !sda_s;
    assign stop_det  = scl_s && scl_d && !sda_d && sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd7;
            rx_shift   <= 7'd0;
            tx_shift   <= 8'd0;
            phase      <= 1'b0;
            sda_o      <= 1'b1;
            tx_req_o   <= 1'b0;
            rx_data_o  <= 8'd0;
            rx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            rw_o       <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            stop_o     <= 1'b0;
            if (stop_det) begin
                state  <= S_IDLE;
                sda_o  <= 1'b1;
                busy_o <= 1'b0;
                stop_o <= 1'b1;
                phase  <= 1'b0;
            end else if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 3'd7;
                sda_o   <= 1'b1;
                busy_o  <= 1'b0;
                phase   <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda_s};
                            if (bit_cnt == 3'd0) begin
                                // rx_shift holds address bits [7:1], sda_s is R/W.
                                if (rx_shift == SLAVE_ADDR) begin
                                    rw_o   <= sda_s;
                                    busy_o <= 1'b1;
                                    phase  <= 1'b0;
                                    state  <= S_ACK_ADDR;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    S_ACK_ADDR, S_ACK_RX: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_o <= 1'b0;
                                phase <= 1'b1;
                            end else begin
                                phase   <= 1'b0;
                                bit_cnt <= 3'd7;
                                if (state == S_ACK_ADDR && rw_o) begin
                                    tx_shift <= tx_data_i;
                                    sda_o    <= tx_data_i[7];
                                    tx_req_o <= 1'b1;
                                    state    <= S_TX_BYTE;
                                end else begin
                                    sda_o <= 1'b1;
                                    state <= S_RX_BYTE;
                                end
                            end
                        end
                    end
                    S_RX_BYTE: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda_s};
                            if (bit_cnt == 3'd0) begin
                                rx_data_o  <= {rx_shift, sda_s};
                                rx_valid_o <= 1'b1;
                                phase      <= 1'b0;
                                state      <= S_ACK_RX;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    S_TX_BYTE: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd0) begin
                                phase <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (phase) begin
                                sda_o <= 1'b1;
                                phase <= 1'b0;
                                state <= S_RX_ACK;
                            end else begin
                                sda_o <= tx_shift[bit_cnt];
                            end
                        end
                    end
                    S_RX_ACK: begin
                        if (scl_rise && !phase) begin
                            if (sda_s) begin
                                busy_o <= 1'b0;
                                state  <= S_IDLE;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            phase    <= 1'b0;
                            bit_cnt  <= 3'd7;
                            tx_shift <= tx_data_i;
                            sda_o    <= tx_data_i[7];
                            tx_req_o <= 1'b1;
                            state    <= S_TX_BYTE;
                        end
                    end
                    default: begin
                        sda_o <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave, with a transaction-level model of what the target must do.
module tb_i2c_slave;

    localparam int Q = 50;          // quarter SCL period: 5 clk
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_line, sda_line;
    logic       scl_o, scl_oe, sda_o, sda_oe;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, busy_o, rw_o, stop_o;

    int tests = 0;
    int fails = 0;

    // Monitor-owned counters and log.
    int         rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, busy_cyc = 0, oe_cyc = 0, bad_pulse = 0;
    logic [7:0] rx_got[$];
    logic       rxv_q = 1'b0, txr_q = 1'b0, stp_q = 1'b0;

    // Stimulus-owned data.
    logic [7:0] wdat[8];
    logic [7:0] tx_arr[8];
    int         tx_base = 0;
    logic [7:0] exp_last = 8'h00;

    assign scl_line  = scl_m;
    assign sda_line  = sda_m & (sda_oe ? sda_o : 1'b1);
    assign tx_data_i = tx_arr[3'(tx_cnt - tx_base)];

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_line), .sda_i(sda_line),
        .scl_o(scl_o), .scl_oe(scl_oe), .sda_o(sda_o), .sda_oe(sda_oe),
        .tx_data_i(tx_data_i), .tx_req_o(tx_req_o), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .busy_o(busy_o), .rw_o(rw_o), .stop_o(stop_o)
    );

    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_got.push_back(rx_data_o);
            rx_cnt++;
        end
        if (tx_req_o) tx_cnt++;
        if (stop_o) stop_cnt++;
        if (busy_o) busy_cyc++;
        if (sda_oe) oe_cyc++;
        if ((rx_valid_o && rxv_q) || (tx_req_o && txr_q) || (stop_o && stp_q) || (stop_o && rx_valid_o))
            bad_pulse++;
        rxv_q = rx_valid_o;
        txr_q = tx_req_o;
        stp_q = stop_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bit_w(input logic b);
        #Q; sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0;
    endtask

    task automatic bit_r(output logic b);
        #Q; sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0;
    endtask

    task automatic start_c;
        #Q; sda_m = 1'b1; #Q; scl_m = 1'b1; #(2*Q); sda_m = 1'b0; #(2*Q); scl_m = 1'b0;
    endtask

    task automatic stop_c;
        #Q; sda_m = 1'b0; #Q; scl_m = 1'b1; #(2*Q); sda_m = 1'b1; #(4*Q);
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(ack);
    endtask

    task automatic byte_r(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        bit_w(nack);
    endtask

    // Full transaction; the model: only ADDR is acked, every write byte is acked and
    // delivered once, reads return the host bytes in order, one tx_req per byte.
    task automatic do_txn(input logic [6:0] addr, input logic rw, input int n, input string tag);
        logic       ack, hit;
        logic [7:0] d;
        int         rx0, tx0, st0, oe0, bz0;
        hit = (addr == ADDR);
        rx0 = rx_cnt; tx0 = tx_cnt; st0 = stop_cnt; oe0 = oe_cyc; bz0 = busy_cyc;
        tx_base = tx_cnt;
        start_c;
        byte_w({addr, rw}, ack);
        check({tag, ".addr_ack"}, 32'(ack), 32'(!hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (!rw) begin
                    byte_w(wdat[i], ack);
                    check({tag, ".data_ack"}, 32'(ack), 32'd0);
                end else begin
                    byte_r(i == n - 1, d);
                    check({tag, ".rd_data"}, 32'(d), 32'(tx_arr[i]));
                end
            end
            if (rw) begin
                #(2*Q);
                check({tag, ".nack_busy"}, 32'(busy_o), 32'd0);
                check({tag, ".nack_oe"}, 32'(sda_oe), 32'd0);
            end
            if (!rw) exp_last = wdat[n-1];
        end
        stop_c;
        check({tag, ".rx_cnt"}, 32'(rx_cnt - rx0), (hit && !rw) ? 32'(n) : 32'd0);
        if (hit && !rw && rx_cnt - rx0 == n)
            for (int i = 0; i < n; i++) check({tag, ".rx_byte"}, 32'(rx_got[rx0+i]), 32'(wdat[i]));
        check({tag, ".tx_req"}, 32'(tx_cnt - tx0), (hit && rw) ? 32'(n) : 32'd0);
        check({tag, ".stop_cnt"}, 32'(stop_cnt - st0), 32'd1);
        check({tag, ".busy_end"}, 32'(busy_o), 32'd0);
        check({tag, ".rx_hold"}, 32'(rx_data_o), 32'(exp_last));
        if (!hit) begin
            check({tag, ".miss_oe"}, 32'(oe_cyc - oe0), 32'd0);
            check({tag, ".miss_busy"}, 32'(busy_cyc - bz0), 32'd0);
        end
    endtask

    task automatic reset_vals(input string tag);
        check({tag, ".sda_o"}, 32'(sda_o), 32'd1);
        check({tag, ".sda_oe"}, 32'(sda_oe), 32'd0);
        check({tag, ".scl"}, {30'd0, scl_o, scl_oe}, 32'd2);
        check({tag, ".rx_data"}, 32'(rx_data_o), 32'd0);
        check({tag, ".flags"}, {27'd0, rx_valid_o, tx_req_o, busy_o, rw_o, stop_o}, 32'd0);
    endtask

    initial begin : main
        logic       ack;
        logic [6:0] a;
        int         rx0;
        for (int i = 0; i < 8; i++) begin
            wdat[i] = 8'h00;
            tx_arr[i] = 8'h00;
        end
        #23;
        reset_vals("reset");
        rst_n = 1'b1;
        #100;

        wdat[0] = 8'hA5;
        do_txn(ADDR, 1'b0, 1, "wr_a5");
        do_txn(7'h51, 1'b0, 1, "wr_miss");
        tx_arr[0] = 8'h3C;
        do_txn(ADDR, 1'b1, 1, "rd_3c");
        wdat[0] = 8'h11; wdat[1] = 8'h22;
        do_txn(ADDR, 1'b0, 2, "wr_2b");

        // STOP after four data bits
        rx0 = rx_cnt;
        start_c;
        byte_w({ADDR, 1'b0}, ack);
        check("abort_stop.ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) bit_w(1'($urandom_range(0, 1)));
        stop_c;
        check("abort_stop.rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        check("abort_stop.rx_hold", 32'(rx_data_o), 32'h22);
        check("abort_stop.busy", 32'(busy_o), 32'd0);

        // repeated START after four data bits, then a read
        start_c;
        byte_w({ADDR, 1'b0}, ack);
        for (int i = 0; i < 4; i++) bit_w(1'($urandom_range(0, 1)));
        tx_arr[0] = 8'h96;
        do_txn(ADDR, 1'b1, 1, "rep_start");
        check("rep_start.no_rx", 32'(rx_cnt - rx0), 32'd0);

        // reset while the address ACK is on the bus
        start_c;
        for (int i = 7; i >= 0; i--) bit_w(i == 0 ? 1'b0 : ADDR[i-1]);
        #Q; sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
        check("rst_ack.driving", 32'(sda_oe), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        reset_vals("rst_ack");
        exp_last = 8'h00;
        #20 rst_n = 1'b1;
        #Q; scl_m = 1'b0;
        stop_c;
        wdat[0] = 8'h5A;
        do_txn(ADDR, 1'b0, 1, "post_rst");

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 2) != 0) a = ADDR;
            else begin
                a = 7'($urandom_range(0, 127));
                if (a == ADDR) a = 7'h51;
            end
            for (int i = 0; i < 8; i++) begin
                wdat[i] = 8'($urandom);
                tx_arr[i] = 8'($urandom);
            end
            do_txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), "rand");
        end

        check("pulse_width", 32'(bad_pulse), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
